// File: rtl/cdc_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_fifo_pkg
//  Purpose  : Shared definitions for the FIFO read-side nibble packer:
//             nibble width and the 2-bit packer FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cdc_fifo_pkg;

    localparam int NIBBLE_WIDTH = 4;
    localparam int BYTE_WIDTH   = 2 * NIBBLE_WIDTH;

    typedef enum logic [1:0] {
        ST_WAIT_FIRST  = 2'd0,
        ST_WAIT_SECOND = 2'd1,
        ST_HOLD        = 2'd2
    } pack_state_t;

endpackage : cdc_fifo_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter with increment enable that sticks at all-ones.
//  Ports    : clk    - clock
//             rst_n  - asynchronous active-low reset, clears count
//             inc    - increment request for this cycle
//             count  - current count value
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_max = '1;
    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fifo_nibble_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_nibble_packer
//  Purpose  : Pops 4-bit nibbles from a show-ahead FIFO read port and packs
//             pairs of them into bytes on a valid/ready output. A pending
//             half byte can be forced out (zero-padded) with flush.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             fifo_empty/fifo_data - FIFO read side (show-ahead)
//             fifo_pop             - read-increment to the FIFO
//             flush                - emit a pending half byte when FIFO empty
//             out_data/out_valid/out_ready/out_padded - byte stream
//             byte_count           - saturating count of transferred bytes
//  Revision : 1.0  initial release
// ============================================================================
module fifo_nibble_packer
    import cdc_fifo_pkg::*;
#(
    parameter bit LOW_FIRST   = 1'b1,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fifo_empty,
    input  logic [NIBBLE_WIDTH-1:0] fifo_data,
    output logic                    fifo_pop,
    input  logic                    flush,
    output logic [BYTE_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_padded,
    output logic [COUNT_WIDTH-1:0]  byte_count
);

    localparam logic [NIBBLE_WIDTH-1:0] c_zero_nibble = '0;

    pack_state_t               r_state;
    logic [NIBBLE_WIDTH-1:0]   r_first;
    logic [BYTE_WIDTH-1:0]     r_out_data;
    logic                      r_out_valid;
    logic                      r_out_padded;

    logic                      w_pop;
    logic                      w_xfer;
    logic [BYTE_WIDTH-1:0]     w_byte_full;
    logic [BYTE_WIDTH-1:0]     w_byte_pad;

    // Byte assembly order: the first popped nibble lands in the low or high
    // half depending on LOW_FIRST; a flushed byte zero-fills the other half.
    generate
        if (LOW_FIRST) begin : g_low_first
            assign w_byte_full = {fifo_data, r_first};
            assign w_byte_pad  = {c_zero_nibble, r_first};
        end else begin : g_high_first
            assign w_byte_full = {r_first, fifo_data};
            assign w_byte_pad  = {r_first, c_zero_nibble};
        end
    endgenerate

    // In HOLD a pop is only allowed when the held byte leaves this cycle, so
    // a new first nibble can be taken in parallel with the transfer.
    // rst_n gates the pop so the FIFO is never advanced during reset.
    always_comb begin
        w_pop = 1'b0;
        if (rst_n && !fifo_empty) begin
            case (r_state)
                ST_WAIT_FIRST:  w_pop = 1'b1;
                ST_WAIT_SECOND: w_pop = 1'b1;
                ST_HOLD:        w_pop = out_ready;
                default:        w_pop = 1'b0;
            endcase
        end
    end

    assign w_xfer = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_WAIT_FIRST;
            r_first      <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_padded <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_FIRST: begin
                    if (w_pop) begin
                        r_first <= fifo_data;
                        r_state <= ST_WAIT_SECOND;
                    end
                end
                ST_WAIT_SECOND: begin
                    // A pop always beats flush: flush only acts on an empty FIFO.
                    if (w_pop) begin
                        r_out_data   <= w_byte_full;
                        r_out_padded <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_state      <= ST_HOLD;
                    end else if (fifo_empty && flush) begin
                        r_out_data   <= w_byte_pad;
                        r_out_padded <= 1'b1;
                        r_out_valid  <= 1'b1;
                        r_state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        if (w_pop) begin
                            r_first <= fifo_data;
                            r_state <= ST_WAIT_SECOND;
                        end else begin
                            r_state <= ST_WAIT_FIRST;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_WAIT_FIRST;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_byte_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_xfer),
        .count (byte_count)
    );

    assign fifo_pop   = w_pop;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_padded = r_out_padded;

endmodule : fifo_nibble_packer
`default_nettype wire

// File: tb/tb_fifo_nibble_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_nibble_packer
//  Purpose  : Directed self-checking bench for fifo_nibble_packer. Three
//             instances share one stimulus: default (LOW_FIRST=1, 8-bit
//             count), LOW_FIRST=0, and COUNT_WIDTH=2. A small FIFO model
//             feeds all three and advances on the default instance's pop.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_nibble_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       out_ready;
    logic       fifo_empty;
    logic [3:0] fifo_data;

    logic [3:0] r_mem [0:63];
    logic [6:0] r_wr_ptr = '0;
    logic [6:0] r_rd_ptr = '0;

    logic       a_pop, a_valid, a_pad;
    logic [7:0] a_data, a_cnt;
    logic       b_pop, b_valid, b_pad;
    logic [7:0] b_data, b_cnt;
    logic       c_pop, c_valid, c_pad;
    logic [7:0] c_data;
    logic [1:0] c_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign fifo_data  = r_mem[r_rd_ptr[5:0]];

    always @(posedge clk) begin
        if (a_pop) r_rd_ptr <= r_rd_ptr + 7'd1;
    end

    fifo_nibble_packer #(.LOW_FIRST(1'b1), .COUNT_WIDTH(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_pop(a_pop), .flush(flush), .out_data(a_data), .out_valid(a_valid),
        .out_ready(out_ready), .out_padded(a_pad), .byte_count(a_cnt));

    fifo_nibble_packer #(.LOW_FIRST(1'b0), .COUNT_WIDTH(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_pop(b_pop), .flush(flush), .out_data(b_data), .out_valid(b_valid),
        .out_ready(out_ready), .out_padded(b_pad), .byte_count(b_cnt));

    fifo_nibble_packer #(.LOW_FIRST(1'b1), .COUNT_WIDTH(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_pop(c_pop), .flush(flush), .out_data(c_data), .out_valid(c_valid),
        .out_ready(out_ready), .out_padded(c_pad), .byte_count(c_cnt));

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] nib);
        r_mem[r_wr_ptr[5:0]] = nib;
        r_wr_ptr = r_wr_ptr + 7'd1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) r_mem[i] = 4'h0;

        // ---------------- reset state, no pop while in reset
        #2;
        push(4'h3);
        push(4'hA);
        tick();
        tick();
        check_value("rst_valid",  32'(a_valid), 32'd0);
        check_value("rst_data",   32'(a_data),  32'h00);
        check_value("rst_padded", 32'(a_pad),   32'd0);
        check_value("rst_count",  32'(a_cnt),   32'd0);
        check_value("rst_pop",    32'(a_pop),   32'd0);
        check_value("rst_pop_c",  32'(c_pop),   32'd0);
        rst_n = 1'b1;
        #1;
        check_value("first_pop_after_rst", 32'(a_pop), 32'd1);

        // ---------------- basic pair 3,A
        tick();
        check_value("ws_pop", 32'(a_pop), 32'd1);
        check_value("ws_valid", 32'(a_valid), 32'd0);
        tick();
        check_value("pair_valid",  32'(a_valid), 32'd1);
        check_value("pair_data_a", 32'(a_data),  32'hA3);
        check_value("pair_data_b", 32'(b_data),  32'h3A);
        check_value("pair_padded", 32'(a_pad),   32'd0);
        check_value("pair_pop_empty", 32'(a_pop), 32'd0);
        tick();
        check_value("pair_xfer_valid", 32'(a_valid), 32'd0);
        check_value("pair_count_a", 32'(a_cnt), 32'd1);
        check_value("pair_count_c", 32'(c_cnt), 32'd1);

        // ---------------- eight nibbles back to back at full rate
        for (int n = 1; n <= 8; n++) push(4'(n));
        #1;
        check_value("burst_pop_k0", 32'(a_pop), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_value("burst_valid", 32'(a_valid), 32'((k % 2 == 0) && (k <= 8)));
            check_value("burst_pop",   32'(a_pop),   32'(k < 8));
            check_value("burst_cnt_a", 32'(a_cnt),   32'(1 + (k - 1) / 2));
            check_value("burst_cnt_c", 32'(c_cnt),   32'(((1 + (k - 1) / 2) > 3) ? 3 : (1 + (k - 1) / 2)));
            if ((k % 2 == 0) && (k <= 8)) begin
                check_value("burst_data_a", 32'(a_data), 32'({4'(k), 4'(k - 1)}));
                check_value("burst_data_b", 32'(b_data), 32'({4'(k - 1), 4'(k)}));
            end
        end

        // ---------------- flush of a single nibble
        push(4'h5);
        tick();
        check_value("flush_pre_valid", 32'(a_valid), 32'd0);
        flush     = 1'b1;
        out_ready = 1'b0;
        tick();
        flush = 1'b0;
        check_value("flush_valid",  32'(a_valid), 32'd1);
        check_value("flush_data_a", 32'(a_data),  32'h05);
        check_value("flush_data_b", 32'(b_data),  32'h50);
        check_value("flush_padded", 32'(a_pad),   32'd1);

        // ---------------- backpressure with a non-empty FIFO
        push(4'h9);
        push(4'h6);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_value("hold_data",  32'(a_data),  32'h05);
            check_value("hold_valid", 32'(a_valid), 32'd1);
            check_value("hold_pop",   32'(a_pop),   32'd0);
        end
        out_ready = 1'b1;
        #1;
        check_value("release_pop", 32'(a_pop), 32'd1);
        tick();
        check_value("release_valid", 32'(a_valid), 32'd0);
        check_value("release_cnt",   32'(a_cnt),   32'd6);
        tick();
        check_value("after_hold_data",   32'(a_data), 32'h69);
        check_value("after_hold_padded", 32'(a_pad),  32'd0);
        tick();
        check_value("after_hold_cnt", 32'(a_cnt), 32'd7);

        // ---------------- flush with nothing pending
        flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_value("idle_flush_valid", 32'(a_valid), 32'd0);
        end
        flush = 1'b0;
        check_value("idle_flush_data", 32'(a_data), 32'h69);
        check_value("idle_flush_cnt",  32'(a_cnt),  32'd7);

        // ---------------- reset while a half byte is pending
        push(4'h7);
        tick();
        check_value("pre_rst_valid", 32'(a_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_valid", 32'(a_valid), 32'd0);
        check_value("mid_rst_cnt_a", 32'(a_cnt),   32'd0);
        check_value("mid_rst_cnt_c", 32'(c_cnt),   32'd0);
        check_value("mid_rst_data",  32'(a_data),  32'h00);
        tick();
        rst_n = 1'b1;
        push(4'hC);
        push(4'hD);
        tick();
        tick();
        check_value("fresh_valid",  32'(a_valid), 32'd1);
        check_value("fresh_data_a", 32'(a_data),  32'hDC);
        check_value("fresh_data_b", 32'(b_data),  32'hCD);
        tick();
        check_value("fresh_cnt_a", 32'(a_cnt), 32'd1);
        check_value("fresh_cnt_c", 32'(c_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule : tb_fifo_nibble_packer
`default_nettype wire

// File: doc/fifo_nibble_packer.md
FIFO_NIBBLE_PACKER -- requirements
Module: fifo_nibble_packer

Interface
REQ-001 Parameter LOW_FIRST, default 1; 1 = first popped nibble forms out_data[3:0], 0 = first popped nibble forms out_data[7:4].
REQ-002 Parameter COUNT_WIDTH, default 8; width of byte_count.
REQ-003 clk  input  1  single clock; same clock as the FIFO read side; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 fifo_empty  input  1  FIFO read-side empty flag; fifo_data valid when low.
REQ-006 fifo_data  input  4  show-ahead FIFO read data at the current read pointer.
REQ-007 fifo_pop  output  1  read-increment pulse to the FIFO; one nibble consumed per high cycle.
REQ-008 flush  input  1  level; forces emission of a pending half byte.
REQ-009 out_data  output  8  assembled byte.
REQ-010 out_valid  output  1  out_data/out_padded valid.
REQ-011 out_ready  input  1  downstream accepts; transfer = out_valid && out_ready at a clock edge.
REQ-012 out_padded  output  1  current byte carries a zero-filled second nibble.
REQ-013 byte_count  output  COUNT_WIDTH  number of transferred bytes, saturating.

Function
REQ-014 FSM states: WAIT_FIRST, WAIT_SECOND, HOLD; reset state WAIT_FIRST.
REQ-015 fifo_pop combinational: high iff !fifo_empty and (state==WAIT_FIRST, or state==WAIT_SECOND, or state==HOLD with out_ready); never high when fifo_empty=1.
REQ-016 WAIT_FIRST, pop: capture fifo_data as first nibble, go WAIT_SECOND; no pop: stay.
REQ-017 WAIT_SECOND, pop: load out_data from first+second nibble per LOW_FIRST, out_padded=0, out_valid=1, go HOLD next cycle (latency: second pop edge to out_valid = 1 cycle).
REQ-018 WAIT_SECOND, fifo_empty=1 and flush=1: load byte with second nibble = 4'h0, out_padded=1, out_valid=1, go HOLD.
REQ-019 WAIT_SECOND, pop and flush both true: pop wins; flush ignored.
REQ-020 flush in WAIT_FIRST or HOLD: no effect.
REQ-021 HOLD: out_data, out_padded, out_valid stable until transfer; no pop without out_ready.
REQ-022 HOLD with transfer and pop same cycle: capture new first nibble, out_valid=0, go WAIT_SECOND (full rate: one byte per two cycles).
REQ-023 HOLD with transfer, no pop: out_valid=0, go WAIT_FIRST.
REQ-024 byte_count increments by 1 per transfer; holds at 2^COUNT_WIDTH-1, no wrap.
REQ-025 out_data and out_padded retain last value when out_valid=0.

Reset
REQ-026 rst_n low asynchronously forces: state WAIT_FIRST, out_valid 0, out_data 8'h00, out_padded 0, byte_count 0, first-nibble register 0; fifo_pop 0 while rst_n low.
REQ-027 Reset mid-operation discards any pending nibble and any untransferred byte; no FIFO pointer restore.
REQ-028 First pop possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package cdc_fifo_pkg holds the FSM state enum (2-bit) and NIBBLE_WIDTH=4 constant.
REQ-030 One sub-module: sat_counter (parameterised width, increment enable, saturate) instantiated for byte_count.
REQ-031 No storage beyond: 4-bit first nibble, 8-bit output byte, padded flag, state, counter.

Verification
REQ-032 Nibbles 4'h3,4'hA pushed, out_ready=1, LOW_FIRST=1 -> one byte out_data=8'hA3, out_padded=0, byte_count=1.
REQ-033 LOW_FIRST=0, nibbles 4'h3,4'hA -> out_data=8'h3A.
REQ-034 Eight nibbles queued, out_ready=1 -> four bytes, out_valid high every other cycle, fifo_pop high every cycle.
REQ-035 Single nibble 4'h5, FIFO empty, flush=1 -> out_data=8'h05, out_padded=1; flush with nothing pending -> no output.
REQ-036 Byte held, out_ready=0 for 10 cycles with FIFO non-empty -> out_data stable, fifo_pop=0 throughout; then out_ready=1 -> transfer and pop in same cycle.
REQ-037 COUNT_WIDTH=2, five transfers -> byte_count 1,2,3,3,3; rst_n pulsed in WAIT_SECOND -> out_valid=0, byte_count=0, next byte built from fresh nibbles only.
